// File: rtl/router_led_pkg.sv
// Shared defaults and helpers for the router port/error LED generator.
package router_led_pkg;

  localparam int unsigned DefaultNumPorts        = 2;
  localparam int unsigned DefaultLedsPerPort     = 8;
  localparam int unsigned DefaultHoldCycles      = 4;
  localparam int unsigned DefaultBlinkHalfCycles = 2;
  localparam int unsigned DefaultErrorHoldCycles = 8;

  localparam logic LED_ON  = 1'b1;
  localparam logic LED_OFF = 1'b0;

  function automatic int unsigned group_base(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/port_led_status_if.sv
// Router-side strobes in, board LED drive out.
interface port_led_status_if
  import router_led_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = DefaultNumPorts,
  parameter int unsigned LEDS_PER_PORT = DefaultLedsPerPort
);
  logic                               clear;
  logic [NUM_PORTS-1:0]               port_hit;
  logic                               error;
  logic [NUM_PORTS*LEDS_PER_PORT-1:0] led;
  logic                               error_active;

  modport master (
    output clear, port_hit, error,
    input  led, error_active
  );

  modport slave (
    input  clear, port_hit, error,
    output led, error_active
  );
endinterface

// File: rtl/led_hold_timer.sv
// Retriggerable down-counter; active while counting, or latched until clear when STICKY.
module led_hold_timer #(
  parameter int unsigned CYCLES = 4,
  parameter bit          STICKY = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic load,
  output logic active
);

  localparam int unsigned Width = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;

  logic [Width-1:0] cnt_d, cnt_q;
  logic             flag_d, flag_q;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clear) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (load) begin
      cnt_d  = Width'(CYCLES);
      flag_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign active = STICKY ? flag_q : (cnt_q != '0);

endmodule

// File: rtl/port_led_status.sv
// Per-port traffic LEDs with hold time, overridden by a full-bank blink on router error.
module port_led_status
  import router_led_pkg::*;
#(
  parameter int unsigned NUM_PORTS         = DefaultNumPorts,
  parameter int unsigned LEDS_PER_PORT     = DefaultLedsPerPort,
  parameter int unsigned HOLD_CYCLES       = DefaultHoldCycles,
  parameter int unsigned BLINK_HALF_CYCLES = DefaultBlinkHalfCycles,
  parameter int unsigned ERROR_HOLD_CYCLES = DefaultErrorHoldCycles
) (
  input logic              clock,
  input logic              reset,
  port_led_status_if.slave bus
);

  localparam int unsigned BlinkWidth = $clog2(BLINK_HALF_CYCLES + 1);
  localparam int unsigned LedWidth   = NUM_PORTS * LEDS_PER_PORT;

  if (HOLD_CYCLES == 0) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (BLINK_HALF_CYCLES == 0) begin : g_bad_blink
    $error("BLINK_HALF_CYCLES must be >= 1");
  end

  logic [NUM_PORTS-1:0] port_lit;
  logic                 err_active;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    led_hold_timer #(
      .CYCLES(HOLD_CYCLES),
      .STICKY(1'b0)
    ) u_hold (
      .clock (clock),
      .reset (reset),
      .clear (bus.clear),
      .load  (bus.port_hit[i]),
      .active(port_lit[i])
    );
  end

  // Zero duration means the error indication latches until clear.
  led_hold_timer #(
    .CYCLES(ERROR_HOLD_CYCLES),
    .STICKY(ERROR_HOLD_CYCLES == 0)
  ) u_err (
    .clock (clock),
    .reset (reset),
    .clear (bus.clear),
    .load  (bus.error),
    .active(err_active)
  );

  logic [BlinkWidth-1:0] bcnt_d, bcnt_q;
  logic                  phase_d, phase_q;

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (bus.clear) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bus.error) begin
      bcnt_d  = '0;
      phase_d = 1'b1;
    end else if (err_active) begin
      if (bcnt_q == BlinkWidth'(BLINK_HALF_CYCLES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BlinkWidth'(1);
      end
    end else begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  // Port timers keep running under the error mask so exit shows live state.
  logic [LedWidth-1:0] led_mux;

  always_comb begin
    led_mux = '0;
    if (err_active) begin
      led_mux = phase_q ? {LedWidth{LED_ON}} : {LedWidth{LED_OFF}};
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        led_mux[group_base(i, LEDS_PER_PORT) +: LEDS_PER_PORT] =
          port_lit[i] ? {LEDS_PER_PORT{LED_ON}} : {LEDS_PER_PORT{LED_OFF}};
      end
    end
  end

  assign bus.led          = led_mux;
  assign bus.error_active = err_active;

endmodule

// File: tb/tb_port_led_status.sv
// Bench for port_led_status: timed-window reference model plus directed literal checks.
module tb_port_led_status;

  localparam int unsigned Np    = 2;
  localparam int unsigned Lpp   = 8;
  localparam int unsigned Hold  = 4;
  localparam int unsigned Blink = 2;
  localparam int unsigned EHold = 8;

  logic          clock;
  logic          reset;
  logic          clear;
  logic          error;
  logic [Np-1:0] hit;

  int checks = 0;
  int passed = 0;

  port_led_status_if #(.NUM_PORTS(Np), .LEDS_PER_PORT(Lpp)) b0 ();
  port_led_status_if #(.NUM_PORTS(Np), .LEDS_PER_PORT(Lpp)) b1 ();

  assign b0.clear    = clear;
  assign b0.error    = error;
  assign b0.port_hit = hit;
  assign b1.clear    = clear;
  assign b1.error    = error;
  assign b1.port_hit = hit;

  port_led_status #(
    .NUM_PORTS(Np), .LEDS_PER_PORT(Lpp), .HOLD_CYCLES(Hold),
    .BLINK_HALF_CYCLES(Blink), .ERROR_HOLD_CYCLES(EHold)
  ) u_dut0 (
    .clock(clock),
    .reset(reset),
    .bus  (b0)
  );

  port_led_status #(
    .NUM_PORTS(Np), .LEDS_PER_PORT(Lpp), .HOLD_CYCLES(Hold),
    .BLINK_HALF_CYCLES(Blink), .ERROR_HOLD_CYCLES(0)
  ) u_dut1 (
    .clock(clock),
    .reset(reset),
    .bus  (b1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model: remember the edge number of the last effective hit/error; outputs follow from age.
  longint n = 0;
  longint last_hit [Np] = '{-1, -1};
  longint last_err = -1;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Np; i++) last_hit[i] = -1;
      last_err = -1;
    end else begin
      n = n + 1;
      if (clear) begin
        for (int i = 0; i < Np; i++) last_hit[i] = -1;
        last_err = -1;
      end else begin
        if (error) last_err = n;
        for (int i = 0; i < Np; i++) if (hit[i]) last_hit[i] = n;
      end
    end
  end

  function automatic logic exp_ea(input bit sticky);
    if (last_err < 0) return 1'b0;
    return sticky || ((n - last_err) < longint'(EHold));
  endfunction

  function automatic logic [15:0] exp_led(input bit sticky);
    logic [15:0] v;
    v = '0;
    if (exp_ea(sticky)) begin
      v = (((n - last_err) / Blink) % 2 == 0) ? 16'hFFFF : 16'h0000;
    end else begin
      for (int i = 0; i < Np; i++)
        if (last_hit[i] >= 0 && (n - last_hit[i]) < longint'(Hold)) v[i*Lpp +: Lpp] = 8'hFF;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    else passed++;
  endtask

  always @(negedge clock) begin
    chk("model_led0", b0.led, exp_led(1'b0));
    chk("model_ea0", {15'b0, b0.error_active}, {15'b0, exp_ea(1'b0)});
    chk("model_led1", b1.led, exp_led(1'b1));
    chk("model_ea1", {15'b0, b1.error_active}, {15'b0, exp_ea(1'b1)});
  end

  task automatic step();
    @(negedge clock);
  endtask

  logic [15:0] err_tbl [8] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
                               16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    error = 1'b0;
    hit   = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("idle_led", b0.led, 16'h0000);
    chk("idle_ea", {15'b0, b0.error_active}, 16'h0000);

    // Reset mid-run with all groups lit.
    hit = 2'b11;
    step();
    hit = '0;
    chk("lit_before_reset", b0.led, 16'hFFFF);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_led", b0.led, 16'h0000);
    chk("async_reset_ea", {15'b0, b0.error_active}, 16'h0000);
    step();
    reset = 1'b0;
    repeat (3) step();
    chk("post_reset_led", b0.led, 16'h0000);

    // Single hit on each port.
    hit = 2'b01;
    step();
    hit = '0;
    for (int k = 0; k < 4; k++) begin
      chk("p0_hold", b0.led, 16'h00FF);
      step();
    end
    chk("p0_expire", b0.led, 16'h0000);
    hit = 2'b10;
    step();
    hit = '0;
    for (int k = 0; k < 4; k++) begin
      chk("p1_hold", b0.led, 16'hFF00);
      step();
    end
    chk("p1_expire", b0.led, 16'h0000);

    // Retrigger at T+2 extends through T+6.
    hit = 2'b01;
    step();
    for (int k = 1; k <= 7; k++) begin
      hit = (k == 2) ? 2'b01 : 2'b00;
      chk("retrigger", b0.led, (k <= 6) ? 16'h00FF : 16'h0000);
      step();
    end
    hit = 2'b11;
    step();
    hit = '0;
    for (int k = 0; k < 4; k++) begin
      chk("both_hold", b0.led, 16'hFFFF);
      step();
    end
    chk("both_expire", b0.led, 16'h0000);

    // Error blink with a port hit just before; hold expires under the mask.
    hit = 2'b01;
    step();
    hit   = '0;
    error = 1'b1;
    step();
    error = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("err_blink", b0.led, err_tbl[k]);
      chk("err_active", {15'b0, b0.error_active}, 16'h0001);
      step();
    end
    chk("err_exit_led", b0.led, 16'h0000);
    chk("err_exit_ea", {15'b0, b0.error_active}, 16'h0000);

    // Sticky build keeps blinking until clear.
    repeat (100) step();
    chk("sticky_ea", {15'b0, b1.error_active}, 16'h0001);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("sticky_clear_led", b1.led, 16'h0000);
    chk("sticky_clear_ea", {15'b0, b1.error_active}, 16'h0000);

    // Clear beats hit and error at the same edge.
    hit   = 2'b11;
    error = 1'b1;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    hit   = '0;
    error = 1'b0;
    chk("clear_prio_led", b0.led, 16'h0000);
    chk("clear_prio_ea", {15'b0, b0.error_active}, 16'h0000);

    // Reset mid-blink; nothing resumes.
    error = 1'b1;
    step();
    error = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    chk("blink_reset_led", b1.led, 16'h0000);
    chk("blink_reset_ea", {15'b0, b1.error_active}, 16'h0000);
    step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("no_resume", b1.led | b0.led, 16'h0000);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      hit[0] = ($urandom_range(0, 3) == 0);
      hit[1] = ($urandom_range(0, 4) == 0);
      error  = ($urandom_range(0, 29) == 0);
      clear  = ($urandom_range(0, 39) == 0);
      step();
    end
    hit   = '0;
    error = 1'b0;
    clear = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/port_led_status.md
Name: port_led_status

Overview:
- Parametrised successor to the router's port/error LED generator. Drives NUM_PORTS groups of LEDS_PER_PORT LEDs.
- Each group lights for a programmable hold time after its port sees traffic. The hold retriggers on every new hit.
- A router error overrides all groups with a full-bank blink for a programmable duration, or until cleared when ERROR_HOLD_CYCLES=0.
- Sits after the router's address-decode/error logic. Feeds the board LEDs directly.

Parameters:
- NUM_PORTS, 2, number of output ports / LED groups (>=1).
- LEDS_PER_PORT, 8, LEDs per group (>=1).
- HOLD_CYCLES, 4, cycles a group stays lit after its last hit (>=1).
- BLINK_HALF_CYCLES, 2, cycles per blink half-period in error mode (>=1).
- ERROR_HOLD_CYCLES, 8, error-mode duration in cycles; 0 means sticky until clear.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of all indication state.
- port_hit  in  NUM_PORTS  per-port traffic strobe; bit i pulses for each packet to port i.
- error  in  1  router error strobe.
- led  out  NUM_PORTS*LEDS_PER_PORT  LED drive; group i = led[i*LEDS_PER_PORT +: LEDS_PER_PORT].
- error_active  out  1  high while error mode is active.

Behaviour:
- Reset (async): all hold counters, error counter, blink counter and blink phase go to 0. led=0 and error_active=0 immediately, with no clock required.
- led and error_active are decoded only from registered state. There is no combinational path from any input to any output.
- Notation: "edge T" is the rising edge that samples an input. "Cycle T+k" is the k-th cycle after that edge.
- Per port i:
  - Counter hcnt_i has width $clog2(HOLD_CYCLES+1).
  - port_hit[i]=1 at an edge: hcnt_i <= HOLD_CYCLES (reload, including retrigger while nonzero).
  - Otherwise, if hcnt_i != 0: hcnt_i decrements.
  - Group i is lit (all ones) iff hcnt_i != 0. A single hit therefore lights the group for cycles T+1..T+HOLD_CYCLES exactly.
  - Ports are independent. Simultaneous hits on several ports all load in the same edge.
- Error mode:
  - error=1 at an edge enters or re-enters error mode: blink phase <= 1 (lit), blink counter <= 0, error counter <= ERROR_HOLD_CYCLES.
  - Error asserted while already in error mode restarts the duration and the blink phase.
  - While active: led = all ones when phase=1, all zeros when phase=0.
  - The blink counter counts 0..BLINK_HALF_CYCLES-1. At wrap it returns to 0 and the phase toggles.
  - The error counter decrements each cycle. Mode ends after ERROR_HOLD_CYCLES cycles.
  - When ERROR_HOLD_CYCLES=0, the mode is sticky until clear or reset. This needs a separate err_active flag, not counter!=0.
  - error_active equals the mode flag.
  - Port hold counters keep running during error mode. Their LEDs are masked, not frozen. On exit, led shows the current port state in the next cycle.
- clear=1 at an edge zeroes all counters and the error flag. It has priority over port_hit and error sampled at the same edge. led=0 from cycle T+1.
- Priority: reset > clear > error > port_hit.
- Counter widths are sized with $clog2(param+1) so no counter wraps. Elaboration-time check: HOLD_CYCLES>=1 and BLINK_HALF_CYCLES>=1.

Decomposition:
- Shared package (router_led_pkg): default parameter values, a function for group slice base index, and LED_ON/LED_OFF fill constants.
- One sub-module, led_hold_timer: a retriggerable down-counter with inputs load/clear and output active. It is instantiated NUM_PORTS times by generate, and reused once for the error duration with a sticky option.

Test Plan (NUM_PORTS=2, LEDS_PER_PORT=8, HOLD_CYCLES=4, BLINK_HALF_CYCLES=2, ERROR_HOLD_CYCLES=8):
1. Assert reset mid-run with led=16'hFFFF → led=16'h0000 and error_active=0 before the next edge. Everything stays 0 after release with idle inputs.
2. port_hit=2'b01 at edge T only → led=16'h00FF in cycles T+1..T+4, then 16'h0000 at T+5. port_hit=2'b10 → 16'hFF00 with identical timing.
3. port_hit[0] at T and T+2 → led=16'h00FF continuously through T+6, then 16'h0000 at T+7. port_hit=2'b11 at T → 16'hFFFF for 4 cycles.
4. error at T with port_hit[0] at T-1 → led for T+1..T+8 = FFFF,FFFF,0000,0000,FFFF,FFFF,0000,0000 and error_active=1 throughout. At T+9, led=0000 and error_active=0 (port hold expired during error).
5. ERROR_HOLD_CYCLES=0 build: error at T → blinking persists 100+ cycles. clear at edge U → led=0 and error_active=0 from U+1.
6. clear together with port_hit=2'b11 and error at edge T → led=16'h0000 and error_active=0 in T+1. Reset asserted mid-blink → immediate 0, and no blink resumes after release.
